pvr_vram_arb: RTL and testbench
===============================

Name: pvr_vram_arb

Overview:
- Arbitrates one PVR VRAM port between three requesters: 0 = region-array parser, 1 = ISP/TSP parameter fetch, 2 = texture fetch.
- Round-robin grant per accepted command.
- Tracks in-flight reads through a latency-matched tag pipeline, so each returning word is steered to the requester that issued it.
- Sits between the PVR front-end fetch engines and the VRAM controller.

Parameters:
- NREQ, 3: number of requesters (indices 0..NREQ-1).
- ADDR_W, 24: VRAM byte-address width.
- RD_LAT, 2: cycles from an accepted read to valid vram_din. Must be 1..8.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_rd  in  NREQ  per-requester read request; held until granted.
- req_wr  in  NREQ  per-requester write request; held until granted.
- req_addr  in  NREQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NREQ*32  packed write data; requester i occupies bits [i*32 +: 32].
- req_gnt  out  NREQ  combinational one-hot grant; the command is accepted at the next rising edge.
- rd_valid  out  NREQ  one-hot; marks rd_data as belonging to requester i.
- rd_data  out  32  read data, shared by all requesters.
- vram_rd  out  1  registered read strobe.
- vram_wr  out  1  registered write strobe.
- vram_addr  out  ADDR_W  registered address.
- vram_dout  out  32  registered write data.
- vram_din  in  32  read data from VRAM.
- vram_wait  in  1  VRAM busy; the current command is not accepted.

Behaviour:
- Reset (asynchronous, active-high):
  - vram_rd=0, vram_wr=0, vram_addr=0, vram_dout=0.
  - rd_valid=0; tag pipeline cleared (all stages invalid).
  - RR pointer=NREQ-1, so requester 0 has first priority.
  - Reads in flight at reset are dropped; their data is never reported.
- Request:
  - req_i = req_rd[i] | req_wr[i].
  - If req_rd[i] and req_wr[i] are both high, it is a write; the read is ignored. The bench flags this as an illegal stimulus.
- Command slot:
  - The slot is free when (vram_rd|vram_wr)==0, or when vram_wait==0.
  - A command is accepted at an edge where (vram_rd|vram_wr)==1 and vram_wait==0.
- Grant, combinational:
  - While the slot is free, req_gnt = one-hot of the first requesting index scanning ptr+1, ptr+2, ... modulo NREQ.
  - req_gnt=0 whenever vram_wait=1 with a command pending, or when no request is active.
- Edge with a grant to k:
  - vram_rd <= req_rd[k] & ~req_wr[k]; vram_wr <= req_wr[k].
  - vram_addr <= addr[k]; vram_dout <= wdata[k].
  - ptr <= k.
- Edge with no grant:
  - If the slot is free, vram_rd and vram_wr <= 0.
  - Otherwise all vram_* hold.
- Requesters advance on the edge where their req_gnt is high. A request may be re-asserted in the next cycle, which gives back-to-back commands at 1 per cycle.
- Tag pipeline:
  - RD_LAT stages of {valid, index}.
  - Stage 0 loads {1, issuing index} on each accepted read, else {0, x}.
  - The pipeline shifts every cycle, unaffected by vram_wait.
  - The last stage is used combinationally: rd_valid = valid ? onehot(index) : 0, and rd_data = vram_din.
  - Timing: a read accepted at edge E appears as rd_valid during the RD_LAT-th cycle after E.
- Writes are fire-and-forget; no response is returned.
- Fairness: with all NREQ requesting continuously, grants rotate 0,1,2,0,...
- A requester that drops its request before being granted loses nothing; the pointer is unchanged.

Decomposition:
- Shared package pvr_pkg:
  - VRAM_ADDR_W=24.
  - Requester index constants REQ_RA=0, REQ_ISP=1, REQ_TEX=2.
  - onehot/index conversion functions.
- Sub-module pvr_rr_pick: combinational round-robin picker (req vector, ptr -> one-hot grant, index). This is reused by the later texture-cache arbiter.

Test Plan:
- Single read: reset, then req_rd[0]=1 with addr 0x1667C0. Expect req_gnt=001 in the same cycle; next cycle vram_rd=1, vram_addr=0x1667C0. With vram_din=0xDEADBEEF, expect rd_valid=001 and rd_data=0xDEADBEEF two cycles after acceptance.
- Round-robin: all three hold req_rd for 6 grants. Expect grant order 0,1,2,0,1,2, and rd_valid order matching, each RD_LAT cycles after its acceptance.
- Stall: vram_wait=1 for 3 cycles while requester 1 reads 0x0D33C8. Expect vram_* held, req_gnt=000 to all during the stall, acceptance on the first cycle vram_wait=0, then rd_valid=010.
- Mixed: requester 2 writes 0x000100 with 0x12345678 while requester 0 reads 0x000200. Expect vram_wr, vram_dout=0x12345678, and no rd_valid for requester 2; only requester 0 gets rd_valid.
- Reset mid-flight: assert reset one cycle after a read is accepted. Expect all outputs 0 immediately and no rd_valid pulse after release; requester 0 is granted first afterwards.
- rd+wr together on requester 1 at 0x000040: expect a write only (vram_wr=1, vram_rd=0) and no rd_valid.

Source files
------------

// File: rtl/pvr_pkg.sv
// Types, constants and one-hot/index helpers shared by the PVR VRAM-side arbiters.
package pvr_pkg;
  localparam int VRAM_ADDR_W = 24;
  localparam int REQ_RA      = 0;
  localparam int REQ_ISP     = 1;
  localparam int REQ_TEX     = 2;
  localparam int MAX_REQ     = 8;

  typedef logic [MAX_REQ-1:0] req_oh_t;
  typedef logic [2:0]         req_idx_t;

  typedef struct packed {
    logic     vld;
    req_idx_t idx;
  } tag_t;

  function automatic req_oh_t idx2oh(req_idx_t idx);
    req_oh_t oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  function automatic req_idx_t oh2idx(req_oh_t oh);
    req_idx_t idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++)
      if (oh[i]) idx = req_idx_t'(i);
    return idx;
  endfunction
endpackage

// File: rtl/pvr_vram_arb_if.sv
// Requester and VRAM-controller signals of the PVR VRAM arbiter.
interface pvr_vram_arb_if import pvr_pkg::*; #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = VRAM_ADDR_W
);
  logic [NREQ-1:0]             req_rd;
  logic [NREQ-1:0]             req_wr;
  logic [NREQ-1:0][ADDR_W-1:0] req_addr;
  logic [NREQ-1:0][31:0]       req_wdata;
  logic [NREQ-1:0]             req_gnt;
  logic [NREQ-1:0]             rd_valid;
  logic [31:0]                 rd_data;
  logic                        vram_rd;
  logic                        vram_wr;
  logic [ADDR_W-1:0]           vram_addr;
  logic [31:0]                 vram_dout;
  logic [31:0]                 vram_din;
  logic                        vram_wait;

  modport slave (
    input  req_rd, req_wr, req_addr, req_wdata, vram_din, vram_wait,
    output req_gnt, rd_valid, rd_data, vram_rd, vram_wr, vram_addr, vram_dout
  );

  modport master (
    output req_rd, req_wr, req_addr, req_wdata, vram_din, vram_wait,
    input  req_gnt, rd_valid, rd_data, vram_rd, vram_wr, vram_addr, vram_dout
  );
endinterface

// File: rtl/pvr_rr_pick.sv
// Combinational round-robin picker: first requester after i_ptr, wrapping modulo NREQ.
module pvr_rr_pick import pvr_pkg::*; #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] i_req,
  input  req_idx_t        i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output req_idx_t        o_idx,
  output logic            o_any
);
  always_comb begin
    int j;
    j     = 0;
    o_gnt = '0;
    o_any = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      j = (int'(i_ptr) + i) % NREQ;
      if (!o_any && i_req[j]) begin
        o_any    = 1'b1;
        o_gnt[j] = 1'b1;
      end
    end
  end

  assign o_idx = oh2idx(MAX_REQ'(o_gnt));
endmodule

// File: rtl/pvr_vram_arb.sv
// Round-robin arbiter for the single PVR VRAM port, with a latency-matched read tag
// pipeline that steers each returning word back to its issuer.
module pvr_vram_arb import pvr_pkg::*; #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int RD_LAT = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  pvr_vram_arb_if.slave  bus
);
  logic                    r_vram_rd, r_vram_wr;
  logic [ADDR_W-1:0]       r_vram_addr;
  logic [31:0]             r_vram_dout;
  req_idx_t                r_ptr, r_idx;
  tag_t [RD_LAT-1:0]       r_tag;

  logic [NREQ-1:0]         w_req, w_pick;
  req_idx_t                w_idx;
  logic                    w_any, w_free, w_grant, w_acc_rd;
  logic                    w_sel_rd, w_sel_wr;
  logic [ADDR_W-1:0]       w_sel_addr;
  logic [31:0]             w_sel_wdata;

  assign w_req    = bus.req_rd | bus.req_wr;
  // A held command frees the slot in the same cycle it is accepted.
  assign w_free   = ~(r_vram_rd | r_vram_wr) | ~bus.vram_wait;
  assign w_acc_rd = r_vram_rd & ~bus.vram_wait;

  pvr_rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_grant     = w_free & w_any;
  assign bus.req_gnt = w_grant ? w_pick : '0;

  always_comb begin
    w_sel_rd    = |(bus.req_rd & w_pick);
    w_sel_wr    = |(bus.req_wr & w_pick);
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick[i]) begin
        w_sel_addr  = w_sel_addr  | bus.req_addr[i];
        w_sel_wdata = w_sel_wdata | bus.req_wdata[i];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vram_rd   <= 1'b0;
      r_vram_wr   <= 1'b0;
      r_vram_addr <= '0;
      r_vram_dout <= '0;
      r_ptr       <= req_idx_t'(NREQ-1);
      r_idx       <= '0;
      r_tag       <= '0;
    end else begin
      r_tag[0] <= '{vld: w_acc_rd, idx: r_idx};
      for (int s = 1; s < RD_LAT; s++)
        r_tag[s] <= r_tag[s-1];
      if (w_grant) begin
        // rd+wr together is treated as a write
        r_vram_rd   <= w_sel_rd & ~w_sel_wr;
        r_vram_wr   <= w_sel_wr;
        r_vram_addr <= w_sel_addr;
        r_vram_dout <= w_sel_wdata;
        r_ptr       <= w_idx;
        r_idx       <= w_idx;
      end else if (w_free) begin
        r_vram_rd <= 1'b0;
        r_vram_wr <= 1'b0;
      end
    end
  end

  assign bus.rd_valid  = r_tag[RD_LAT-1].vld ? NREQ'(idx2oh(r_tag[RD_LAT-1].idx)) : '0;
  assign bus.rd_data   = bus.vram_din;
  assign bus.vram_rd   = r_vram_rd;
  assign bus.vram_wr   = r_vram_wr;
  assign bus.vram_addr = r_vram_addr;
  assign bus.vram_dout = r_vram_dout;
endmodule

// File: tb/tb_pvr_vram_arb.sv
// Directed bench for pvr_vram_arb: cycle table for round-robin/mixed traffic plus
// hand sequences for single read, stall, reset mid-flight and rd+wr collision.
module tb_pvr_vram_arb;
  import pvr_pkg::*;
  localparam int NREQ = 3;
  localparam int AW   = 24;
  localparam int LAT  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pvr_vram_arb_if #(.NREQ(NREQ), .ADDR_W(AW)) bus ();

  pvr_vram_arb #(.NREQ(NREQ), .ADDR_W(AW), .RD_LAT(LAT)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always @(posedge clk)
    if (!rst && |(bus.req_rd & bus.req_wr))
      $display("note: illegal stimulus, rd+wr together on requesters %b", bus.req_rd & bus.req_wr);

  typedef struct {
    logic [2:0]  rd;
    logic [2:0]  wr;
    logic [2:0]  gnt;
    logic        vrd;
    logic        vwr;
    logic [23:0] addr;
    logic [31:0] dout;
    logic [2:0]  vld;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_rd = '0;
    bus.req_wr = '0;
    bus.vram_wait = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [2:0] gnt, input logic vrd, input logic vwr,
                         input logic [23:0] addr, input logic [2:0] vld);
    chk({tag, ".gnt"},  64'(bus.req_gnt),   64'(gnt));
    chk({tag, ".vrd"},  64'(bus.vram_rd),   64'(vrd));
    chk({tag, ".vwr"},  64'(bus.vram_wr),   64'(vwr));
    chk({tag, ".addr"}, 64'(bus.vram_addr), 64'(addr));
    chk({tag, ".vld"},  64'(bus.rd_valid),  64'(vld));
  endtask

  initial begin
    bus.req_rd    = '0;
    bus.req_wr    = '0;
    bus.vram_wait = 1'b0;
    bus.vram_din  = 32'h0;
    bus.req_addr[0]  = 24'h000200;
    bus.req_addr[1]  = 24'h000040;
    bus.req_addr[2]  = 24'h000100;
    bus.req_wdata[0] = 32'hA0A0A0A0;
    bus.req_wdata[1] = 32'hB1B1B1B1;
    bus.req_wdata[2] = 32'h12345678;

    // round-robin with all three reading, then drain
    tbl[0]  = '{3'b111, 3'b000, 3'b001, 1'b0, 1'b0, 24'h000000, 32'h00000000, 3'b000};
    tbl[1]  = '{3'b111, 3'b000, 3'b010, 1'b1, 1'b0, 24'h000200, 32'hA0A0A0A0, 3'b000};
    tbl[2]  = '{3'b111, 3'b000, 3'b100, 1'b1, 1'b0, 24'h000040, 32'hB1B1B1B1, 3'b000};
    tbl[3]  = '{3'b111, 3'b000, 3'b001, 1'b1, 1'b0, 24'h000100, 32'h12345678, 3'b001};
    tbl[4]  = '{3'b111, 3'b000, 3'b010, 1'b1, 1'b0, 24'h000200, 32'hA0A0A0A0, 3'b010};
    tbl[5]  = '{3'b111, 3'b000, 3'b100, 1'b1, 1'b0, 24'h000040, 32'hB1B1B1B1, 3'b100};
    tbl[6]  = '{3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 24'h000100, 32'h12345678, 3'b001};
    tbl[7]  = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 24'h000100, 32'h12345678, 3'b010};
    tbl[8]  = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 24'h000100, 32'h12345678, 3'b100};
    tbl[9]  = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 24'h000100, 32'h12345678, 3'b000};
    // mixed: requester 2 writes while requester 0 reads
    tbl[10] = '{3'b001, 3'b100, 3'b001, 1'b0, 1'b0, 24'h000100, 32'h12345678, 3'b000};
    tbl[11] = '{3'b000, 3'b100, 3'b100, 1'b1, 1'b0, 24'h000200, 32'hA0A0A0A0, 3'b000};
    tbl[12] = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 24'h000100, 32'h12345678, 3'b000};
    tbl[13] = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 24'h000100, 32'h12345678, 3'b001};
    tbl[14] = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 24'h000100, 32'h12345678, 3'b000};

    // reset state
    #2;
    chk("rst.vrd",  64'(bus.vram_rd),   64'd0);
    chk("rst.vwr",  64'(bus.vram_wr),   64'd0);
    chk("rst.addr", 64'(bus.vram_addr), 64'd0);
    chk("rst.dout", 64'(bus.vram_dout), 64'd0);
    chk("rst.vld",  64'(bus.rd_valid),  64'd0);
    chk("rst.gnt",  64'(bus.req_gnt),   64'd0);
    do_reset();

    for (int r = 0; r < 15; r++) begin
      bus.req_rd = tbl[r].rd;
      bus.req_wr = tbl[r].wr;
      #1;
      chk_out($sformatf("tbl%0d", r), tbl[r].gnt, tbl[r].vrd, tbl[r].vwr, tbl[r].addr, tbl[r].vld);
      chk($sformatf("tbl%0d.dout", r), 64'(bus.vram_dout), 64'(tbl[r].dout));
      tick();
    end

    // single read with data return two cycles after acceptance
    do_reset();
    bus.req_addr[0] = 24'h1667C0;
    bus.req_rd = 3'b001;
    #1;
    chk("single.gnt", 64'(bus.req_gnt), 64'(3'b001));
    tick();
    bus.req_rd = 3'b000;
    #1;
    chk_out("single.c1", 3'b000, 1'b1, 1'b0, 24'h1667C0, 3'b000);
    tick();
    bus.vram_din = 32'hDEADBEEF;
    #1;
    chk_out("single.c2", 3'b000, 1'b0, 1'b0, 24'h1667C0, 3'b000);
    tick();
    chk("single.vld",  64'(bus.rd_valid), 64'(3'b001));
    chk("single.data", 64'(bus.rd_data),  64'h00000000DEADBEEF);
    tick();
    chk("single.vld_off", 64'(bus.rd_valid), 64'(3'b000));

    // stall: command held while vram_wait, others locked out
    do_reset();
    bus.req_addr[1] = 24'h0D33C8;
    bus.req_rd = 3'b010;
    #1;
    chk("stall.gnt0", 64'(bus.req_gnt), 64'(3'b010));
    tick();
    bus.req_rd = 3'b101;
    bus.vram_wait = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk_out($sformatf("stall.w%0d", c), 3'b000, 1'b1, 1'b0, 24'h0D33C8, 3'b000);
      tick();
    end
    bus.req_rd = 3'b000;
    bus.vram_wait = 1'b0;
    #1;
    chk_out("stall.acc", 3'b000, 1'b1, 1'b0, 24'h0D33C8, 3'b000);
    tick();
    chk_out("stall.p1", 3'b000, 1'b0, 1'b0, 24'h0D33C8, 3'b000);
    tick();
    chk("stall.vld", 64'(bus.rd_valid), 64'(3'b010));
    tick();
    chk("stall.vld_off", 64'(bus.rd_valid), 64'(3'b000));

    // reset while a read is in flight
    do_reset();
    bus.req_addr[0] = 24'h1667C0;
    bus.req_rd = 3'b010;
    #1;
    tick();
    bus.req_rd = 3'b000;
    tick();
    rst = 1'b1;
    #1;
    chk_out("rmid.async", 3'b000, 1'b0, 1'b0, 24'h000000, 3'b000);
    tick();
    rst = 1'b0;
    #1;
    chk("rmid.novld0", 64'(bus.rd_valid), 64'(3'b000));
    tick();
    chk("rmid.novld1", 64'(bus.rd_valid), 64'(3'b000));
    bus.req_rd = 3'b111;
    #1;
    chk("rmid.gnt", 64'(bus.req_gnt), 64'(3'b001));
    tick();
    bus.req_rd = 3'b000;

    // rd+wr on requester 1 is a write with no response
    do_reset();
    bus.req_addr[1] = 24'h000040;
    bus.req_rd = 3'b010;
    bus.req_wr = 3'b010;
    #1;
    chk("rdwr.gnt", 64'(bus.req_gnt), 64'(3'b010));
    tick();
    bus.req_rd = 3'b000;
    bus.req_wr = 3'b000;
    #1;
    chk_out("rdwr.cmd", 3'b000, 1'b0, 1'b1, 24'h000040, 3'b000);
    chk("rdwr.dout", 64'(bus.vram_dout), 64'h00000000B1B1B1B1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("rdwr.novld%0d", c), 64'(bus.rd_valid), 64'(3'b000));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
